// File: rtl/timeout_share_arbiter_if.sv
// Handshake bundle between requesters and the shared timeout arbiter.
interface timeout_share_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 4
) ();
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] load_val;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic [CW-1:0]      count;
  logic [NREQ-1:0]    done_pulse;

  // Requester side
  modport master (
    output req, load_val,
    input  grant, busy, count, done_pulse
  );

  // Arbiter side
  modport slave (
    input  req, load_val,
    output grant, busy, count, done_pulse
  );
endinterface

// File: rtl/timeout_share_arbiter.sv
// One CW-bit timeout down-counter shared round-robin among NREQ requesters.
// A granted requester gets its own length counted down and a one-cycle done_pulse.
module timeout_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 4
) (
  input logic                      clk,
  input logic                      rst,
  timeout_share_arbiter_if.slave   bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e          state_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic [CW-1:0]   count_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win_q;

  logic [CW-1:0]   lv [NREQ];
  logic            any_req;
  logic [IW-1:0]   win_idx;
  logic [CW-1:0]   win_len;
  logic [31:0]     cand;
  logic [IW-1:0]   next_ptr;

  // Round-robin winner: scan offsets from high to low so the closest set req to ptr wins.
  always_comb begin
    cand    = '0;
    win_idx = '0;
    any_req = |bus.req;
    for (int unsigned i = 0; i < NREQ; i++) begin
      lv[i] = bus.load_val[i*CW +: CW];
    end
    for (int unsigned k = NREQ; k > 0; k--) begin
      cand = 32'(ptr_q) + k - 32'd1;
      if (cand >= NREQ) cand = cand - NREQ;
      if (bus.req[cand[IW-1:0]]) win_idx = cand[IW-1:0];
    end
    // A zero length would never finish; treat it as one cycle.
    win_len = (lv[win_idx] == '0) ? CW'(1) : lv[win_idx];
  end

  assign next_ptr = (win_q == LastIdx) ? '0 : win_q + IW'(1);

  // Arbitration and countdown FSM with registered grant/count/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q <= NREQ'(1) << win_idx;
            count_q <= win_len;
            win_q   <= win_idx;
            state_q <= StCount;
          end
        end
        StCount: begin
          // Abort takes priority over completion.
          if (!bus.req[win_q]) begin
            grant_q <= '0;
            count_q <= '0;
            ptr_q   <= next_ptr;
            state_q <= StIdle;
          end else if (count_q == CW'(1)) begin
            grant_q <= '0;
            count_q <= '0;
            done_q  <= grant_q;
            ptr_q   <= next_ptr;
            state_q <= StDone;
          end else begin
            count_q <= count_q - CW'(1);
          end
        end
        StDone: begin
          done_q  <= '0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          done_q  <= '0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.done_pulse = done_q;
  assign bus.count      = count_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_timeout_share_arbiter.sv
// Scoreboard bench: a schedule-based model predicts grants and done pulses by edge number;
// a negedge monitor pops and compares whenever the DUT shows a grant or a done pulse.
module tb_timeout_share_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timeout_share_arbiter_if #(.NREQ(N), .CW(W)) bus ();

  timeout_share_arbiter #(.NREQ(N), .CW(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {int idx; int len; int cyc;} gexp_t;
  typedef struct {int idx; int cyc;} dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];
  gexp_t ge;
  dexp_t de;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  bit rst_seen = 1'b0;
  int dones_seen = 0;

  // Model: who holds the timer, the grant edge, its length, and the earliest next arbitration.
  bit m_active   = 1'b0;
  int m_owner    = 0;
  int m_g        = 0;
  int m_len      = 0;
  int m_ptr      = 0;
  int m_next_arb = 0;
  bit finished [N];

  logic [N-1:0] prev_g = '0;
  int cur_len = 0;
  int cur_cyc = 0;

  task automatic check(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, ecnt, act, expv);
    end
  endtask

  // Timeline rules: grant at edge g visible for len cycles, done after edge g+len,
  // next arbitration two edges later; an abort frees the timer for the very next edge.
  task automatic model_edge();
    logic [N-1:0] r;
    int w;
    int lv;
    r = bus.req;
    rst_seen = rst;
    if (rst) begin
      m_active   = 1'b0;
      m_ptr      = 0;
      m_next_arb = ecnt + 1;
      return;
    end
    if (m_active) begin
      if (!r[m_owner]) begin
        m_active   = 1'b0;
        m_ptr      = (m_owner + 1) % N;
        m_next_arb = ecnt + 1;
      end else if (ecnt == m_g + m_len) begin
        dq.push_back('{m_owner, ecnt});
        finished[m_owner] = 1'b1;
        m_active   = 1'b0;
        m_ptr      = (m_owner + 1) % N;
        m_next_arb = ecnt + 2;
      end
    end else if (ecnt >= m_next_arb && r != '0) begin
      w = 0;
      for (int k = 0; k < N; k++) begin
        if (r[(m_ptr + k) % N]) begin
          w = (m_ptr + k) % N;
          break;
        end
      end
      lv = int'(bus.load_val[w*W +: W]);
      m_len = (lv == 0) ? 1 : lv;
      gq.push_back('{w, m_len, ecnt});
      m_active = 1'b1;
      m_owner  = w;
      m_g      = ecnt;
      finished[w] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    ecnt++;
    model_edge();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: sample after each edge's outputs settle.
  always @(negedge clk) begin
    if (ecnt > 0) begin
      if (rst_seen) begin
        check("reset_zero", int'({bus.grant, bus.done_pulse, bus.count, bus.busy}), 0);
      end
      check("busy", int'(bus.busy), int'(bus.grant != '0 || bus.done_pulse != '0));
      check("grant_done_excl", int'(bus.grant != '0 && bus.done_pulse != '0), 0);
      check("grant_onehot", int'($onehot0(bus.grant)), 1);
      check("done_onehot", int'($onehot0(bus.done_pulse)), 1);
      if (bus.grant != '0) begin
        if (bus.grant != prev_g) begin
          if (gq.size() == 0) begin
            check("grant_unexpected", int'(bus.grant), 0);
            cur_len = int'(bus.count);
            cur_cyc = ecnt;
          end else begin
            ge = gq.pop_front();
            check("grant_vec", int'(bus.grant), 1 << ge.idx);
            check("grant_cyc", ecnt, ge.cyc);
            cur_len = ge.len;
            cur_cyc = ge.cyc;
          end
        end
        check("count", int'(bus.count), cur_len - (ecnt - cur_cyc));
      end else begin
        check("count_idle", int'(bus.count), 0);
      end
      if (bus.done_pulse != '0) begin
        dones_seen++;
        if (dq.size() == 0) begin
          check("done_unexpected", int'(bus.done_pulse), 0);
        end else begin
          de = dq.pop_front();
          check("done_vec", int'(bus.done_pulse), 1 << de.idx);
          check("done_cyc", ecnt, de.cyc);
        end
      end
      prev_g = bus.grant;
    end
  end

  initial begin
    bus.req      = '0;
    bus.load_val = '0;
    for (int i = 0; i < N; i++) finished[i] = 1'b0;
    rst = 1'b1;
    steps(2);
    rst = 1'b0;

    // Single requester, length 3
    bus.load_val[0*W +: W] = 4'd3;
    bus.req = 4'b0001;
    steps(7);
    bus.req = '0;
    steps(3);

    // All held, length 2: fairness order
    bus.load_val = {4'd2, 4'd2, 4'd2, 4'd2};
    bus.req = 4'b1111;
    steps(22);
    bus.req = '0;
    steps(4);

    // Abort mid-count
    bus.load_val[1*W +: W] = 4'd5;
    bus.req = 4'b0010;
    steps(3);
    bus.req = '0;
    steps(4);

    // Zero length behaves as one
    bus.load_val[2*W +: W] = 4'd0;
    bus.req = 4'b0100;
    steps(4);
    bus.req = '0;
    steps(3);

    // Reset during count, then all request
    bus.load_val[3*W +: W] = 4'd4;
    bus.req = 4'b1000;
    steps(2);
    rst = 1'b1;
    bus.req = 4'b1111;
    step();
    rst = 1'b0;
    steps(15);
    bus.req = '0;
    steps(4);

    // load_val changed during count is ignored
    bus.load_val[0*W +: W] = 4'd6;
    bus.req = 4'b0001;
    steps(2);
    bus.load_val[0*W +: W] = 4'd2;
    steps(9);
    bus.req = '0;
    steps(3);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.req[i] = 1'b1;
            finished[i] = 1'b0;
            bus.load_val[i*W +: W] = ($urandom_range(0, 9) == 0) ?
                                     W'($urandom_range(8, 15)) : W'($urandom_range(0, 5));
          end
        end else if (finished[i] && $urandom_range(0, 3) != 0) begin
          bus.req[i] = 1'b0;
        end else if ($urandom_range(0, 49) == 0) begin
          bus.req[i] = 1'b0;
        end
        if ($urandom_range(0, 9) == 0) bus.load_val[i*W +: W] = W'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    bus.req = '0;
    steps(25);

    check("grant_queue_empty", gq.size(), 0);
    check("done_queue_empty", dq.size(), 0);
    check("dones_nonzero", int'(dones_seen > 0), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
